// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch requester, data requester and
// memory-side signals of the shared instruction/data memory port.
// The arbiter connects through the slave modport; the pipeline and memory
// model connect through the master modport.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Fetch (IF stage) requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  // Data (MEM stage) requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_funct3;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;

  // Memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_funct3;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_done, if_rdata, if_stall,
    input  d_req, d_we, d_addr, d_wdata, d_funct3,
    output d_done, d_rdata, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_funct3,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_done, if_rdata, if_stall,
    output d_req, d_we, d_addr, d_wdata, d_funct3,
    input  d_done, d_rdata, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_funct3,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between instruction fetch
// and the load/store stage using a request/done handshake.
// Data accesses win ties (older instruction); a burst counter bounds how many
// consecutive data grants may pass a pending fetch.
// Optional build macro: MEM_ARB_PERF_EN adds perf_conflicts and
// perf_stall_cycles counter outputs.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DATA_BASE   = 512,
  parameter int unsigned D_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_conflicts,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam logic [3:0]        BURST_MAX_C = 4'(D_BURST_MAX);
  localparam logic [ADDR_W-1:0] DATA_BASE_C = ADDR_W'(DATA_BASE);
  localparam logic [2:0]        FUNCT3_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_funct3_q, mem_funct3_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [3:0]        dburst_cnt_q, dburst_cnt_d;
  logic              data_win_s;

  // Data addresses live above the data region base; the sum wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] map_data_addr(input logic [ADDR_W-1:0] addr);
    return addr + DATA_BASE_C;
  endfunction

  // Burst counter increment that never exceeds the configured maximum.
  function automatic logic [3:0] burst_inc(input logic [3:0] cnt);
    if (cnt >= BURST_MAX_C) begin
      return BURST_MAX_C;
    end else begin
      return cnt + 4'd1;
    end
  endfunction

  // Data is granted unless a fetch is waiting and the data burst budget is spent.
  assign data_win_s = bus.d_req & (~bus.if_req | (dburst_cnt_q < BURST_MAX_C));

  // Next-state, grant decision and command/response next values.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    if_done_d    = 1'b0;
    d_done_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    dburst_cnt_d = dburst_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (data_win_s) begin
          state_d      = ST_BUSY_D;
          mem_req_d    = 1'b1;
          mem_we_d     = bus.d_we;
          mem_addr_d   = map_data_addr(bus.d_addr);
          mem_wdata_d  = bus.d_wdata;
          mem_funct3_d = bus.d_funct3;
          if (bus.if_req) begin
            dburst_cnt_d = burst_inc(dburst_cnt_q);
          end else begin
            dburst_cnt_d = 4'd0;
          end
        end else if (bus.if_req) begin
          state_d      = ST_BUSY_I;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_funct3_d = FUNCT3_WORD;
          dburst_cnt_d = 4'd0;
        end else begin
          state_d      = ST_IDLE;
        end
      end

      ST_BUSY_I: begin
        if (bus.mem_ack) begin
          state_d    = ST_DONE;
          mem_req_d  = 1'b0;
          if_rdata_d = bus.mem_rdata;
          if_done_d  = 1'b1;
        end else begin
          state_d    = ST_BUSY_I;
        end
      end

      ST_BUSY_D: begin
        if (bus.mem_ack) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          d_rdata_d = bus.mem_rdata;
          d_done_d  = 1'b1;
        end else begin
          state_d   = ST_BUSY_D;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory command, response and fairness registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= 3'b000;
      if_done_q    <= 1'b0;
      d_done_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      dburst_cnt_q <= 4'd0;
    end else begin
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      if_done_q    <= if_done_d;
      d_done_q     <= d_done_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      dburst_cnt_q <= dburst_cnt_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_funct3 = mem_funct3_q;
  assign bus.if_done    = if_done_q;
  assign bus.d_done     = d_done_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_rdata    = d_rdata_q;

  // Stalls are combinational so the pipeline releases in the done cycle.
  assign bus.if_stall   = bus.if_req & ~if_done_q;
  assign bus.d_stall    = bus.d_req & ~d_done_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflicts_q;
  logic [31:0] perf_stall_cycles_q;

  // Conflict and stall counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_conflicts_q    <= 32'd0;
      perf_stall_cycles_q <= 32'd0;
    end else begin
      if ((state_q == ST_IDLE) && bus.if_req && bus.d_req) begin
        perf_conflicts_q <= perf_conflicts_q + 32'd1;
      end else begin
        perf_conflicts_q <= perf_conflicts_q;
      end
      if (bus.if_stall || bus.d_stall) begin
        perf_stall_cycles_q <= perf_stall_cycles_q + 32'd1;
      end else begin
        perf_stall_cycles_q <= perf_stall_cycles_q;
      end
    end
  end

  assign perf_conflicts    = perf_conflicts_q;
  assign perf_stall_cycles = perf_stall_cycles_q;
`endif

endmodule
